prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the instruction memory: loads a program image into the instruction RAM write port over a byte stream, replacing the simulation-only file preload.
- Assembles 16-bit instruction words from bytes and writes them to consecutive word addresses starting at 0.
- Verifies an XOR checksum.
- Holds the CPU (PC/fetch) in reset until the image has loaded successfully.

Parameters:
- COL, 16, instruction word width in bits (must equal 2 bytes).
- ROW_I, 15, instruction memory depth in words; maximum accepted program length.
- ADDR_W, 4, word-address width (matches PC bits [4:1]).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction RAM write-enable pulse.
- mem_addr  output  ADDR_W  instruction RAM word address.
- mem_wdata  output  COL  instruction word to write.
- words_loaded  output  ADDR_W+1  count of words written this session.
- cpu_hold  output  1  keeps PC/fetch in reset while high.
- done  output  1  image loaded and checksum matched (sticky).
- error  output  1  bad length or checksum mismatch (sticky).

Behaviour:
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, cpu_hold=1, done=0, error=0, checksum accumulator=0.
- A byte is accepted only on a cycle where in_valid & in_ready are both high. in_ready is combinational from state: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK; 0 otherwise.
- Image format, in order:
  - length high byte, length low byte (N words);
  - N words, each high byte first;
  - 1 checksum byte equal to the XOR of all preceding bytes, length bytes included.
- Checksum accumulator XORs in every accepted byte except the checksum byte.
- State transitions:
  - IDLE: on start -> LEN_HI. Clears words_loaded, accumulator, done and error; cpu_hold=1.
  - LEN_HI: on accept, latch length[15:8] -> LEN_LO.
  - LEN_LO: on accept, latch length[7:0]. Full 16-bit length of 0 or > ROW_I -> ERR; else -> DATA_HI.
  - DATA_HI: on accept, latch hi byte -> DATA_LO.
  - DATA_LO: on accept, register mem_wdata={hi,in_data}, mem_addr=words_loaded[ADDR_W-1:0], mem_we=1 next cycle, words_loaded+1. If the new count == N -> CHK, else -> DATA_HI.
  - CHK: on accept, in_data == accumulator -> DONE; else -> ERR.
  - DONE: done=1, cpu_hold=0. start -> LEN_HI (new session: done cleared, cpu_hold=1).
  - ERR: error=1, cpu_hold=1. start -> LEN_HI (error cleared).
- Latency: mem_we pulses exactly one cycle, in the cycle after the low byte is accepted. Addresses and data are stable while mem_we is high.
- start while in LEN_HI..CHK is ignored; no restart mid-session.
- in_valid while in_ready=0 is not consumed, and the byte is not counted.
- Back-to-back bytes every cycle are supported with no bubbles.
- rst mid-session: returns to IDLE with reset values. Words already written stay in RAM, but done=0 and cpu_hold=1, so the CPU never runs a partial image.
- words_loaded saturates by construction at N ≤ ROW_I; it does not wrap.

Decomposition:
- Shared package (`Parameter.v` defines): COL, ROW_I, ADDR_W, plus loader state encodings LD_IDLE, LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_CHK, LD_DONE, LD_ERR (3-bit).
- One natural sub-module, byte_pair_assembler: holds the hi byte and produces the 16-bit word plus a one-cycle word_valid. The FSM, counters and checksum stay in prog_loader.

Test Plan:
- Nominal load: start, then stream 00 02 12 34 AB CD 42 every cycle -> mem_we at addr 0 with 0x1234, then addr 1 with 0xABCD. words_loaded=2, done=1, cpu_hold=0, error=0.
- Bad checksum: same image with final byte 0x43 -> both words written, error=1, done=0, cpu_hold=1.
- Bad length: 00 00, and separately 00 10 (16 > ROW_I=15) -> ERR right after the second byte, no mem_we, in_ready=0.
- Backpressure/gaps: in_valid toggled randomly, plus in_valid held while the loader is in IDLE -> identical writes to the nominal case; no bytes consumed in IDLE.
- Reset mid-load: rst after the first word is written -> next cycle state=IDLE, cpu_hold=1, done=0, words_loaded=0. A subsequent full load then succeeds.
- Reload from DONE: after the nominal load, start plus a 1-word image 00 01 FF FF 01 -> done drops and cpu_hold rises during the session. Addr 0 = 0xFFFF, done=1 again.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared widths and loader state encodings
package prog_loader_pkg;
  localparam int COL    = 16;
  localparam int ROW_I  = 15;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_LEN_HI  = 3'd1,
    LD_LEN_LO  = 3'd2,
    LD_DATA_HI = 3'd3,
    LD_DATA_LO = 3'd4,
    LD_CHK     = 3'd5,
    LD_DONE    = 3'd6,
    LD_ERR     = 3'd7
  } ld_state_t;
endpackage

// File: rtl/prog_loader_byte_pair_assembler.sv
// rtl/prog_loader_byte_pair_assembler.sv - joins hi/lo bytes into one registered instruction word
module byte_pair_assembler
  import prog_loader_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           hi_en,
  input  logic           lo_en,
  input  logic [7:0]     byte_data,
  output logic [COL-1:0] word,
  output logic           word_valid
);
  logic [7:0] hi_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_byte    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= lo_en;
      if (hi_en) hi_byte <= byte_data;
      // word holds its value until the next low byte, so it is stable around the write pulse
      if (lo_en) word <= {hi_byte, byte_data};
    end
  end
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a length/words/checksum image into instruction RAM, holding the CPU until it verifies
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [COL-1:0]    mem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  ld_state_t       state, state_nxt;
  logic            accept;
  logic            idle_like;
  logic [7:0]      len_hi;
  logic [ADDR_W:0] len_n;
  logic [7:0]      acc;
  logic [15:0]     len_full;
  logic            len_bad;
  logic [ADDR_W:0] count_inc;

  byte_pair_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .hi_en      (accept && state == LD_DATA_HI),
    .lo_en      (accept && state == LD_DATA_LO),
    .byte_data  (in_data),
    .word       (mem_wdata),
    .word_valid (mem_we)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_CHK: in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    accept    = in_valid && in_ready;
    idle_like = (state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERR);
    len_full  = {len_hi, in_data};
    len_bad   = (len_full == 16'd0) || (len_full > 16'(ROW_I));
    count_inc = words_loaded + (ADDR_W+1)'(1);

    case (state)
      LD_IDLE, LD_DONE, LD_ERR: if (start) state_nxt = LD_LEN_HI;
      LD_LEN_HI:  if (accept) state_nxt = LD_LEN_LO;
      LD_LEN_LO:  if (accept) state_nxt = len_bad ? LD_ERR : LD_DATA_HI;
      LD_DATA_HI: if (accept) state_nxt = LD_DATA_LO;
      LD_DATA_LO: if (accept) state_nxt = (count_inc == len_n) ? LD_CHK : LD_DATA_HI;
      LD_CHK:     if (accept) state_nxt = (in_data == acc) ? LD_DONE : LD_ERR;
      default:    state_nxt = LD_IDLE;
    endcase
  end

  // done/error are sticky because DONE and ERR are only left on a new start
  assign done     = (state == LD_DONE);
  assign error    = (state == LD_ERR);
  assign cpu_hold = (state != LD_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LD_IDLE;
      len_hi       <= '0;
      len_n        <= '0;
      acc          <= '0;
      words_loaded <= '0;
      mem_addr     <= '0;
    end else begin
      state <= state_nxt;
      if (idle_like && start) begin
        words_loaded <= '0;
        acc          <= '0;
      end
      if (accept && state != LD_CHK) acc <= acc ^ in_data;
      if (accept && state == LD_LEN_HI) len_hi <= in_data;
      // only the low bits matter: any length that fits ROW_I is routed onward
      if (accept && state == LD_LEN_LO) len_n <= len_full[ADDR_W:0];
      if (accept && state == LD_DATA_LO) begin
        mem_addr     <= words_loaded[ADDR_W-1:0];
        words_loaded <= count_inc;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, mem_we, cpu_hold, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [COL-1:0]    mem_wdata;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int failures = 0;
  logic [ADDR_W+COL-1:0] wq[$];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .words_loaded(words_loaded), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W+COL-1:0] e;
        e = wq.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+COL-1:COL]));
        check("wr_data", 32'(mem_wdata), 32'(e[COL-1:0]));
      end
    end
  end

  // Reference: parse the image by its format rules, queue the writes, predict the outcome
  task automatic model_image(input logic [7:0] img[$], output int consume,
                             output bit e_done, output bit e_err, output int e_words);
    int n;
    logic [7:0] x;
    n = {img[0], img[1]};
    e_done = 0; e_err = 0; e_words = 0;
    if (n == 0 || n > ROW_I) begin
      consume = 2; e_err = 1;
      return;
    end
    for (int w = 0; w < n; w++) wq.push_back({4'(w), img[2+2*w], img[3+2*w]});
    x = 8'h00;
    for (int i = 0; i < 2 + 2*n; i++) x ^= img[i];
    consume = 3 + 2*n;
    e_words = n;
    e_done = (img[2+2*n] == x);
    e_err = !e_done;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit stray);
    int waited;
    @(negedge clk);
    start = 1'b0;
    if ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0; in_data = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1; in_data = b; start = stray;
    waited = 0;
    while (!in_ready && waited < 50) begin @(negedge clk); waited++; end
    if (!in_ready) check("byte_accept_timeout", 32'(in_ready), 32'd1);
    else @(posedge clk);
  endtask

  task automatic run_image(input logic [7:0] img[$], input int gap_pct, input bit stray);
    int consume, e_words;
    bit e_done, e_err;
    do_start();
    check("session_done_low", 32'(done), 32'd0);
    check("session_hold_high", 32'(cpu_hold), 32'd1);
    model_image(img, consume, e_done, e_err, e_words);
    for (int i = 0; i < consume; i++) send_byte(img[i], gap_pct, stray && i == 3);
    @(negedge clk); in_valid = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    check("done", 32'(done), 32'(e_done));
    check("error", 32'(error), 32'(e_err));
    check("cpu_hold", 32'(cpu_hold), 32'(!e_done));
    check("words_loaded", 32'(words_loaded), 32'(e_words));
    check("in_ready_end", 32'(in_ready), 32'd0);
    check("writes_pending", 32'(wq.size()), 32'd0);
    wq.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] img[$];
    logic [7:0] x;
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b0;

    // in_valid held while idle must not consume anything
    in_valid = 1'b1; in_data = 8'h00;
    repeat (5) @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);

    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_image(img, 0, 0);
    img = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'h01};
    run_image(img, 0, 0);
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    run_image(img, 0, 0);
    img = '{8'h00, 8'h00};
    run_image(img, 0, 0);
    img = '{8'h00, 8'h10};
    run_image(img, 0, 0);
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_image(img, 60, 1);

    // reset after the first word is written
    wq.push_back({4'd0, 16'h1234});
    do_start();
    send_byte(8'h00, 0, 0); send_byte(8'h02, 0, 0);
    send_byte(8'h12, 0, 0); send_byte(8'h34, 0, 0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_pending", 32'(wq.size()), 32'd0);
    rst = 1'b0;
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_image(img, 30, 0);

    for (int t = 0; t < 24; t++) begin
      int r;
      r = $urandom_range(9);
      if (r < 7) n = $urandom_range(1, ROW_I);
      else if (r == 7) n = 0;
      else n = $urandom_range(16, 300);
      img.delete();
      img.push_back(8'(n >> 8));
      img.push_back(8'(n));
      x = img[0] ^ img[1];
      if (n >= 1 && n <= ROW_I) begin
        for (int i = 0; i < 2*n; i++) begin
          img.push_back(8'($urandom));
          x ^= img[img.size()-1];
        end
        if ($urandom_range(3) == 0) img.push_back(x ^ 8'($urandom_range(1, 255)));
        else img.push_back(x);
      end
      run_image(img, (t % 3) * 30, t % 4 == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
